// File: rtl/alu_result_buffer.sv
// alu_result_buffer: ALU result FIFO with valid/ready handshakes, flags register and jump predicate.
// Define ALU_SIGN_FLAG_EN to add the neg_flag output and the N / !N jump conditions.
module alu_result_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_zero,
    input  logic                    in_carry,
    input  logic                    FI,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    zero_flag,
    output logic                    carry_flag,
`ifdef ALU_SIGN_FLAG_EN
    output logic                    neg_flag,
`endif
    input  logic [2:0]              cond_sel,
    output logic                    cond_true,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              zero_q, zero_d, carry_q, carry_d;
    logic              push, pop, wr_en, neg;

`ifdef ALU_SIGN_FLAG_EN
    localparam bit N_EN = 1'b1;
    logic neg_q, neg_d;
    always_comb neg_d = (push & FI) ? in_data[DATA_W-1] : neg_q;
    always_ff @(posedge clk) begin
        if (!rst_n) neg_q <= 1'b0;
        else        neg_q <= neg_d;
    end
    assign neg      = neg_q;
    assign neg_flag = neg_q;
`else
    localparam bit N_EN = 1'b0;
    assign neg = 1'b0;
`endif

    assign in_ready   = count_q != CNT_W'(DEPTH);
    assign out_valid  = count_q != '0;
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign count      = count_q;

    // Flags follow every accepted push with FI, even one dropped by flush.
    always_comb begin
        push     = in_valid & in_ready;
        pop      = out_valid & out_ready;
        wr_en    = push & ~flush;
        wr_ptr_d = flush ? '0 : !push ? wr_ptr_q :
                   (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        rd_ptr_d = flush ? '0 : !pop ? rd_ptr_q :
                   (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        count_d  = flush ? '0 : (push && !pop) ? count_q + CNT_W'(1) :
                   (!push && pop) ? count_q - CNT_W'(1) : count_q;
        zero_d   = (push & FI) ? in_zero  : zero_q;
        carry_d  = (push & FI) ? in_carry : carry_q;
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = zero_q;
            3'b010: cond_true = carry_q;
            3'b011: cond_true = ~zero_q;
            3'b100: cond_true = N_EN & neg;
            3'b101: cond_true = N_EN & ~neg;
            3'b110: cond_true = ~carry_q;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: table-driven directed checks of alu_result_buffer (DEPTH=2, DATA_W=8).
module tb_alu_result_buffer;
`ifdef ALU_SIGN_FLAG_EN
    localparam logic N_EN = 1'b1;
`else
    localparam logic N_EN = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, in_zero = 1'b0, in_carry = 1'b0, FI = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [2:0] cond_sel = 3'b000;
    logic       in_ready, out_valid, zero_flag, carry_flag, cond_true;
    logic [7:0] out_data;
    logic [1:0] count;
`ifdef ALU_SIGN_FLAG_EN
    logic       neg_flag;
`endif

    alu_result_buffer #(.DATA_W(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_zero(in_zero), .in_carry(in_carry), .FI(FI), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
`ifdef ALU_SIGN_FLAG_EN
        .neg_flag(neg_flag),
`endif
        .cond_sel(cond_sel), .cond_true(cond_true), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       z, c, fi, fl, ordy;
        logic [2:0] sel;
        logic       e_ir, e_ov;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
        logic       e_zf, e_cf, e_ct, e_nf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic iv, logic [7:0] d, logic z, logic c, logic fi, logic fl,
                               logic ordy, logic [2:0] sel, logic e_ir, logic e_ov,
                               logic [7:0] e_od, logic [1:0] e_cnt, logic e_zf, logic e_cf,
                               logic e_ct, logic e_nf);
        vec_t t;
        t.iv = iv; t.d = d; t.z = z; t.c = c; t.fi = fi; t.fl = fl; t.ordy = ordy; t.sel = sel;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od; t.e_cnt = e_cnt;
        t.e_zf = e_zf; t.e_cf = e_cf; t.e_ct = e_ct; t.e_nf = e_nf;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_state(input string tag, input vec_t t);
        chk({tag, ".in_ready"}, int'(in_ready), int'(t.e_ir));
        chk({tag, ".out_valid"}, int'(out_valid), int'(t.e_ov));
        chk({tag, ".out_data"}, int'(out_data), int'(t.e_od));
        chk({tag, ".count"}, int'(count), int'(t.e_cnt));
        chk({tag, ".zero_flag"}, int'(zero_flag), int'(t.e_zf));
        chk({tag, ".carry_flag"}, int'(carry_flag), int'(t.e_cf));
        chk({tag, ".cond_true"}, int'(cond_true), int'(t.e_ct));
`ifdef ALU_SIGN_FLAG_EN
        chk({tag, ".neg_flag"}, int'(neg_flag), int'(t.e_nf));
`endif
    endtask

    // Drive one row at the falling edge; expected values describe outputs before the next rising edge.
    task automatic apply(input string tag, input vec_t t);
        @(negedge clk);
        in_valid = t.iv; in_data = t.d; in_zero = t.z; in_carry = t.c;
        FI = t.fi; flush = t.fl; out_ready = t.ordy; cond_sel = t.sel;
        #1;
        check_state(tag, t);
    endtask

    initial begin
        vec_t t;
        logic [7:0] head;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_state("reset", v(0, 8'h00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 8'h00, 0, 0, 0, 1, 0));
        rst_n = 1'b1;

        // Fill to full, blocked push, pop while full, drain, empty pop ignored
        tbl.push_back(v(1, 8'h12, 0, 0, 0, 0, 0, 3'b000, 1, 0, 8'h00, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 8'h34, 0, 0, 0, 0, 0, 3'b000, 1, 1, 8'h12, 1, 0, 0, 1, 0));
        tbl.push_back(v(1, 8'h56, 0, 0, 0, 0, 0, 3'b000, 0, 1, 8'h12, 2, 0, 0, 1, 0));
        tbl.push_back(v(1, 8'h78, 0, 0, 0, 0, 1, 3'b000, 0, 1, 8'h12, 2, 0, 0, 1, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 1, 3'b000, 1, 1, 8'h34, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 1, 3'b000, 1, 0, 8'h00, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 8'hA0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 8'h00, 0, 0, 0, 1, 0));
        foreach (tbl[i]) apply($sformatf("fill%0d", i), tbl[i]);

        // Simultaneous push and pop at count 1 across several pointer wraps
        head = 8'hA0;
        for (int i = 0; i < 10; i++) begin
            t = v(1, 8'(8'hA1 + i), 0, 0, 0, 0, 1, 3'b000, 1, 1, head, 1, 0, 0, 1, 0);
            apply($sformatf("wrap%0d", i), t);
            head = 8'(8'hA1 + i);
        end

        // Flags, predicate, flush while full and flush dropping a push
        tbl.delete();
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 1, 3'b000, 1, 1, 8'hAA, 1, 0, 0, 1, 0));
        tbl.push_back(v(1, 8'h00, 1, 1, 1, 0, 0, 3'b001, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 0, 3'b001, 1, 1, 8'h00, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 0, 3'b011, 1, 1, 8'h00, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 0, 3'b110, 1, 1, 8'h00, 1, 1, 1, 0, 0));
        tbl.push_back(v(1, 8'h5A, 0, 0, 0, 0, 0, 3'b010, 1, 1, 8'h00, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 0, 0, 3'b000, 0, 1, 8'h00, 2, 1, 1, 1, 0));
        tbl.push_back(v(1, 8'hFF, 0, 0, 1, 1, 0, 3'b111, 0, 1, 8'h00, 2, 1, 1, 0, 0));
        tbl.push_back(v(1, 8'h3C, 1, 0, 0, 0, 0, 3'b000, 1, 0, 8'h00, 0, 1, 1, 1, 0));
        tbl.push_back(v(1, 8'hFF, 0, 0, 1, 1, 0, 3'b100, 1, 1, 8'h3C, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 0, 3'b100, 1, 0, 8'h00, 0, 0, 0, N_EN, N_EN));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 0, 3'b101, 1, 0, 8'h00, 0, 0, 0, 0, N_EN));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 0, 3'b011, 1, 0, 8'h00, 0, 0, 0, 1, N_EN));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 0, 3'b110, 1, 0, 8'h00, 0, 0, 0, 1, N_EN));
        tbl.push_back(v(1, 8'hC3, 0, 0, 0, 0, 0, 3'b000, 1, 0, 8'h00, 0, 0, 0, 1, N_EN));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 1, 3'b000, 1, 1, 8'hC3, 1, 0, 0, 1, N_EN));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 8'h00, 0, 0, 0, 1, N_EN));
        tbl.push_back(v(1, 8'h11, 1, 1, 1, 0, 0, 3'b000, 1, 0, 8'h00, 0, 0, 0, 1, N_EN));
        tbl.push_back(v(1, 8'h92, 0, 1, 0, 0, 0, 3'b000, 1, 1, 8'h11, 1, 1, 1, 1, 0));
        foreach (tbl[i]) apply($sformatf("flag%0d", i), tbl[i]);

        // Reset mid-stream beats flush and a flag-loading push
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 8'h33; FI = 1'b1;
        in_zero = 1'b1; in_carry = 1'b1; out_ready = 1'b0; cond_sel = 3'b000;
        #1;
        chk("prerst.count", int'(count), 2);
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; FI = 1'b0; in_zero = 1'b0; in_carry = 1'b0;
        #1;
        check_state("midrst", v(0, 8'h00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 8'h00, 0, 0, 0, 1, 0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
